// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared definitions for the RAM arbiter slice.
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF : default RAM geometry (16K x 8)
//   state_e                         : access sequencer states
package ram_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 14;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester-side bundle of the RAM arbiter.
//   port 0 (CPU) and port 1 (loader/front panel): req/write/addr/wdata in,
//   ack out; shared rdata_out and one-hot grant_out.
//   master : requester view (drives requests)
//   slave  : arbiter view (drives acks, read data, grant)
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  req0_in;
  logic                  write0_in;
  logic [ADDR_WIDTH-1:0] addr0_in;
  logic [DATA_WIDTH-1:0] wdata0_in;
  logic                  ack0_out;

  logic                  req1_in;
  logic                  write1_in;
  logic [ADDR_WIDTH-1:0] addr1_in;
  logic [DATA_WIDTH-1:0] wdata1_in;
  logic                  ack1_out;

  logic [DATA_WIDTH-1:0] rdata_out;
  logic [1:0]            grant_out;

  modport master (
    output req0_in, write0_in, addr0_in, wdata0_in,
    output req1_in, write1_in, addr1_in, wdata1_in,
    input  ack0_out, ack1_out, rdata_out, grant_out
  );

  modport slave (
    input  req0_in, write0_in, addr0_in, wdata0_in,
    input  req1_in, write1_in, addr1_in, wdata1_in,
    output ack0_out, ack1_out, rdata_out, grant_out
  );

endinterface : ram_arbiter_if

// File: rtl/ram_arbiter_rr_pick2.sv
// ram_arbiter_rr_pick2: 2-way round-robin select (combinational).
//   req_i[1:0] : pending requests
//   last_i     : 1 when port 1 was granted last
//   gnt_c_o    : one-hot winner, 00 when nothing requests
module ram_arbiter_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_c_o
);

  // On a tie the port that was not granted last wins.
  always_comb begin
    gnt_c_o = 2'b00;
    case (req_i)
      2'b01:   gnt_c_o = 2'b01;
      2'b10:   gnt_c_o = 2'b10;
      2'b11:   gnt_c_o = last_i ? 2'b01 : 2'b10;
      default: gnt_c_o = 2'b00;
    endcase
  end

endmodule : ram_arbiter_rr_pick2

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between two requesters.
//   clk_in / rst_in : clock, asynchronous active-high reset
//   req_if          : requester bundle (slave view)
//   ram_write_out   : RAM write strobe, high only in ACCESS of a write
//   ram_addr_out    : RAM address, registered at grant
//   ram_bus_io      : RAM data bus; driven with write data only while writing
// Each access walks IDLE -> ACCESS -> CAPTURE -> DONE, ack pulses in DONE.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  ram_arbiter_if.slave          req_if,
  output logic                  ram_write_out,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  inout  wire  [DATA_WIDTH-1:0] ram_bus_io
);

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  last_q, last_d;
  logic                  wr_flag_q, wr_flag_d;
  logic                  ram_write_q, ram_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [1:0]            pick_c;

  ram_arbiter_rr_pick2 u_pick (
    .req_i   ({req_if.req1_in, req_if.req0_in}),
    .last_i  (last_q),
    .gnt_c_o (pick_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      wr_flag_q   <= 1'b0;
      ram_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      wr_flag_q   <= wr_flag_d;
      ram_write_q <= ram_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    wr_flag_d   = wr_flag_q;
    ram_write_d = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_c != 2'b00) begin
          state_d = ST_ACCESS;
          grant_d = pick_c;
          last_d  = pick_c[1];
          if (pick_c[1]) begin
            addr_d      = req_if.addr1_in;
            wdata_d     = req_if.wdata1_in;
            wr_flag_d   = req_if.write1_in;
            ram_write_d = req_if.write1_in;
          end else begin
            addr_d      = req_if.addr0_in;
            wdata_d     = req_if.wdata0_in;
            wr_flag_d   = req_if.write0_in;
            ram_write_d = req_if.write0_in;
          end
        end
      end
      ST_ACCESS: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d = ST_DONE;
        if (!wr_flag_q) rdata_d = ram_bus_io;
        ack0_d = grant_q[0];
        ack1_d = grant_q[1];
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe only rises in ACCESS, so the RAM never drives at the same time.
  assign ram_bus_io    = ram_write_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign ram_write_out = ram_write_q;
  assign ram_addr_out  = addr_q;

  assign req_if.ack0_out  = ack0_q;
  assign req_if.ack1_out  = ack1_q;
  assign req_if.rdata_out = rdata_q;
  assign req_if.grant_out = grant_q;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: bench for ram_arbiter with a behavioural 16K x 8 RAM.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_write;
  logic [13:0] ram_addr;
  wire  [7:0]  ram_bus;

  logic [7:0]  mem [0:16383];
  logic        mem_clr;
  logic        mon_en;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] ref_mem [int];
  bit         ref_last;
  logic [7:0] ref_rdata;

  always #5 clk = ~clk;

  ram_arbiter_if arb_if ();

  ram_arbiter dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .req_if        (arb_if),
    .ram_write_out (ram_write),
    .ram_addr_out  (ram_addr),
    .ram_bus_io    (ram_bus)
  );

  // RAM: drives the bus whenever not being written, samples writes on posedge
  assign ram_bus = ram_write ? 8'bzzzzzzzz : mem[ram_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 8'h00;
    end else if (ram_write) begin
      mem[ram_addr] <= ram_bus;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  // Every cycle: strobe only in the first granted cycle; bus otherwise owned by RAM
  int gcnt = 0;
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (arb_if.grant_out != 2'b00) gcnt++;
      else gcnt = 0;
      check("mon_write_outside_access", 32'(ram_write && (gcnt != 1)), 32'd0);
      if (!ram_write) check("mon_bus_not_driven", 32'(ram_bus), 32'(mem[ram_addr]));
    end else begin
      gcnt = 0;
    end
  end

  task automatic idle_inputs();
    arb_if.req0_in = 1'b0; arb_if.write0_in = 1'b0; arb_if.addr0_in = '0; arb_if.wdata0_in = '0;
    arb_if.req1_in = 1'b0; arb_if.write1_in = 1'b0; arb_if.addr1_in = '0; arb_if.wdata1_in = '0;
  endtask

  // One arbitration round: called at a negedge in IDLE, returns at a negedge in IDLE.
  task automatic round(input bit r0, input bit w0, input logic [13:0] a0, input logic [7:0] d0,
                       input bit r1, input bit w1, input logic [13:0] a1, input logic [7:0] d1);
    bit         w [2];
    logic [13:0] a [2];
    logic [7:0]  d [2];
    int          order [$];
    int          p;
    logic [1:0]  g;
    w[0] = w0; a[0] = a0; d[0] = d0;
    w[1] = w1; a[1] = a1; d[1] = d1;
    if (r0 && r1) begin
      if (ref_last) begin order.push_back(0); order.push_back(1); end
      else          begin order.push_back(1); order.push_back(0); end
    end else if (r0) order.push_back(0);
    else if (r1)     order.push_back(1);
    arb_if.req0_in = r0; arb_if.write0_in = w0; arb_if.addr0_in = a0; arb_if.wdata0_in = d0;
    arb_if.req1_in = r1; arb_if.write1_in = w1; arb_if.addr1_in = a1; arb_if.wdata1_in = d1;
    for (int k = 0; k < order.size(); k++) begin
      p = order[k];
      g = (p == 0) ? 2'b01 : 2'b10;
      if (w[p]) ref_mem[int'(a[p])] = d[p];
      else      ref_rdata = ref_rd(int'(a[p]));
      ref_last = (p == 1);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (c < 4) begin
          check("grant", 32'(arb_if.grant_out), 32'(g));
          check("ack0", 32'(arb_if.ack0_out), 32'(c == 3 && p == 0));
          check("ack1", 32'(arb_if.ack1_out), 32'(c == 3 && p == 1));
          if (c == 1) begin
            check("ram_write", 32'(ram_write), 32'(w[p]));
            check("ram_addr", 32'(ram_addr), 32'(a[p]));
            if (w[p]) check("ram_wdata", 32'(ram_bus), 32'(d[p]));
          end
          if (c == 3) begin
            check("rdata", 32'(arb_if.rdata_out), 32'(ref_rdata));
            if (p == 0) arb_if.req0_in = 1'b0;
            else        arb_if.req1_in = 1'b0;
          end
        end else begin
          check("idle_grant", 32'(arb_if.grant_out), 32'd0);
          check("idle_acks", 32'({arb_if.ack1_out, arb_if.ack0_out}), 32'd0);
        end
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", 32'(arb_if.grant_out), 32'd0);
    check("rst_acks", 32'({arb_if.ack1_out, arb_if.ack0_out}), 32'd0);
    check("rst_rdata", 32'(arb_if.rdata_out), 32'd0);
    check("rst_ram_write", 32'(ram_write), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_bus_free", 32'(ram_bus), 32'(mem[ram_addr]));
  endtask

  initial begin
    int acks;
    int idx;
    logic [13:0] t4_addr [3];
    rst = 1'b1; mem_clr = 1'b1; mon_en = 1'b0;
    ref_last = 1'b1; ref_rdata = 8'h00;
    idle_inputs();
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0; mon_en = 1'b1;

    // Port 0 write then read
    round(1, 1, 14'h1234, 8'hA5, 0, 0, '0, '0);
    round(1, 0, 14'h1234, 8'h00, 0, 0, '0, '0);
    check("t2_rdata_a5", 32'(arb_if.rdata_out), 32'hA5);

    // Asynchronous reset mid-sim
    rst = 1'b1;
    #1;
    check_reset_outputs();
    ref_last = 1'b1; ref_rdata = 8'h00;
    @(negedge clk);
    rst = 1'b0;

    // Port 1 holds its request for three back-to-back reads
    t4_addr[0] = 14'h3FFE; t4_addr[1] = 14'h3FFF; t4_addr[2] = 14'h0000;
    for (int i = 0; i < 3; i++) round(0, 0, '0, '0, 1, 1, t4_addr[i], 8'($urandom_range(1, 255)));
    arb_if.req1_in = 1'b1; arb_if.write1_in = 1'b0; arb_if.addr1_in = t4_addr[0];
    acks = 0; idx = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("t4_ack1", 32'(arb_if.ack1_out), 32'((c % 4) == 3));
      check("t4_grant", 32'(arb_if.grant_out), ((c % 4) == 0) ? 32'd0 : 32'd2);
      if (arb_if.ack1_out) begin
        acks++;
        if (idx < 3) check("t4_rdata", 32'(arb_if.rdata_out), 32'(ref_rd(int'(t4_addr[idx]))));
        idx++;
        if (idx < 3) arb_if.addr1_in = t4_addr[idx];
        else         arb_if.req1_in = 1'b0;
      end
    end
    check("t4_ack_count", 32'(acks), 32'd3);
    ref_last = 1'b1;
    ref_rdata = ref_rd(0);

    // Simultaneous writes from both ports, then readback
    round(1, 1, 14'h0001, 8'h11, 1, 1, 14'h0002, 8'h22);
    round(1, 0, 14'h0001, 8'h00, 0, 0, '0, '0);
    check("t3_rd1", 32'(arb_if.rdata_out), 32'h11);
    round(0, 0, '0, '0, 1, 0, 14'h0002, 8'h00);
    check("t3_rd2", 32'(arb_if.rdata_out), 32'h22);

    // Reset during ACCESS of a write: lost, no ack
    arb_if.req0_in = 1'b1; arb_if.write0_in = 1'b1;
    arb_if.addr0_in = 14'h0100; arb_if.wdata0_in = 8'h5A;
    @(negedge clk);
    check("t5_access_write", 32'(ram_write), 32'd1);
    check("t5_access_grant", 32'(arb_if.grant_out), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_write_drop", 32'(ram_write), 32'd0);
    check("t5_grant_clear", 32'(arb_if.grant_out), 32'd0);
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_no_ack", 32'({arb_if.ack1_out, arb_if.ack0_out}), 32'd0);
    end
    rst = 1'b0;
    ref_last = 1'b1; ref_rdata = 8'h00;
    round(1, 0, 14'h0100, 8'h00, 0, 0, '0, '0);
    check("t5_readback", 32'(arb_if.rdata_out), 32'h00);

    // Randomized rounds against the reference model
    for (int n = 0; n < 60; n++) begin
      bit r0, r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      round(r0, 1'($urandom_range(0, 1)), 14'(14'h2000 + $urandom_range(0, 15)), 8'($urandom),
            r1, 1'($urandom_range(0, 1)), 14'(14'h2000 + $urandom_range(0, 15)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ram_arbiter
